// File: rtl/video_in_pkg.sv
// Shared types and bus widths for the video_in Wishbone fill path.
package video_in_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

endpackage

// File: rtl/wb_watchdog.sv
// ACK watchdog: counts consecutive stalled strobe cycles and flags the one
// that reaches TIMEOUT; an ACK on that same cycle suppresses the flag.
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic nRST,
  input  logic clr,
  input  logic stall,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count and timeout flag for the current cycle
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (stall) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        timeout = 1'b1;
        cnt_d   = {CNT_W{1'b0}};
      end else if (cnt_q != CNT_W'(TIMEOUT)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!nRST) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_fill_arbiter.sv
// Two-master Wishbone burst arbiter for the video_in RAM port: fixed priority
// to m0 with an m1 anti-starvation limit, LOCK hold-over and an ACK watchdog.
module wb_fill_arbiter
  import video_in_pkg::*;
#(
  parameter int ADR_W      = 32,
  parameter int MAX_CONSEC = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic                m0_wb_CYC_I,
  input  logic                m0_wb_STB_I,
  input  logic                m0_wb_LOCK_I,
  input  logic [WB_SEL_W-1:0] m0_wb_SEL_I,
  input  logic                m0_wb_WE_I,
  input  logic [ADR_W-1:0]    m0_wb_ADR_I,
  output logic                m0_wb_ACK_O,
  output logic [WB_DAT_W-1:0] m0_wb_DAT_O,
  output logic                m0_err,
  input  logic                m1_wb_CYC_I,
  input  logic                m1_wb_STB_I,
  input  logic                m1_wb_LOCK_I,
  input  logic [WB_SEL_W-1:0] m1_wb_SEL_I,
  input  logic                m1_wb_WE_I,
  input  logic [ADR_W-1:0]    m1_wb_ADR_I,
  output logic                m1_wb_ACK_O,
  output logic [WB_DAT_W-1:0] m1_wb_DAT_O,
  output logic                m1_err,
  input  logic [WB_DAT_W-1:0] p_wb_DAT_I,
  input  logic                p_wb_ACK_I,
  output logic                p_wb_CYC_O,
  output logic                p_wb_STB_O,
  output logic                p_wb_LOCK_O,
  output logic                p_wb_WE_O,
  output logic [WB_SEL_W-1:0] p_wb_SEL_O,
  output logic [ADR_W-1:0]    p_wb_ADR_O,
  output logic [1:0]          grant
);

  localparam int CONSEC_W = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;

  arb_state_t            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [CONSEC_W-1:0]   consec_q, consec_d;
  logic [1:0]            err_q, err_d;

  logic                  owner_cyc_s, owner_stb_s, owner_lock_s, owner_we_s;
  logic [WB_SEL_W-1:0]   owner_sel_s;
  logic [ADR_W-1:0]      owner_adr_s;
  logic                  owning_s, release_s, stall_s, wd_clr_s, wd_timeout_s;
  logic                  consec_max_s;
  logic [CONSEC_W-1:0]   consec_up_s;

  // Signals of whichever master the grant register points at
  always_comb begin
    owner_cyc_s  = m0_wb_CYC_I;
    owner_stb_s  = m0_wb_STB_I;
    owner_lock_s = m0_wb_LOCK_I;
    owner_we_s   = m0_wb_WE_I;
    owner_sel_s  = m0_wb_SEL_I;
    owner_adr_s  = m0_wb_ADR_I;
    if (grant_q[1]) begin
      owner_cyc_s  = m1_wb_CYC_I;
      owner_stb_s  = m1_wb_STB_I;
      owner_lock_s = m1_wb_LOCK_I;
      owner_we_s   = m1_wb_WE_I;
      owner_sel_s  = m1_wb_SEL_I;
      owner_adr_s  = m1_wb_ADR_I;
    end else begin
      owner_cyc_s  = m0_wb_CYC_I;
    end
  end

  assign owning_s     = (state_q == OWN0) || (state_q == OWN1);
  assign release_s    = ~owner_cyc_s & ~owner_lock_s;
  assign stall_s      = owning_s & owner_stb_s & ~p_wb_ACK_I;
  // Release wins over a coincident timeout; the next owner starts from zero.
  assign wd_clr_s     = ~owning_s | release_s;
  assign consec_max_s = (consec_q == CONSEC_W'(MAX_CONSEC));
  assign consec_up_s  = consec_max_s ? consec_q : consec_q + CONSEC_W'(1);

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .nRST    (nRST),
    .clr     (wd_clr_s),
    .stall   (stall_s),
    .timeout (wd_timeout_s)
  );

  // Ownership FSM, grant, consecutive-m0 counter and error pulses
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    consec_d = consec_q;
    err_d    = 2'b00;
    case (state_q)
      IDLE: begin
        if (m0_wb_CYC_I && (!m1_wb_CYC_I || !consec_max_s)) begin
          state_d  = OWN0;
          grant_d  = 2'b01;
          consec_d = m1_wb_CYC_I ? consec_up_s : {CONSEC_W{1'b0}};
        end else if (m1_wb_CYC_I) begin
          state_d  = OWN1;
          grant_d  = 2'b10;
          consec_d = {CONSEC_W{1'b0}};
        end else begin
          state_d  = IDLE;
        end
      end
      OWN0: begin
        if (release_s) begin
          if (m1_wb_CYC_I) begin
            state_d  = OWN1;
            grant_d  = 2'b10;
            consec_d = {CONSEC_W{1'b0}};
          end else begin
            state_d  = IDLE;
            grant_d  = 2'b00;
          end
        end else if (wd_timeout_s) begin
          state_d = ABORT;
          err_d   = 2'b01;
        end else begin
          state_d = OWN0;
        end
      end
      OWN1: begin
        if (release_s) begin
          if (m0_wb_CYC_I) begin
            state_d  = OWN0;
            grant_d  = 2'b01;
            consec_d = m1_wb_CYC_I ? consec_up_s : {CONSEC_W{1'b0}};
          end else begin
            state_d  = IDLE;
            grant_d  = 2'b00;
          end
        end else if (wd_timeout_s) begin
          state_d = ABORT;
          err_d   = 2'b10;
        end else begin
          state_d = OWN1;
        end
      end
      ABORT: begin
        // Grant still names the aborted master; wait for it to let go.
        if (!owner_cyc_s) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else begin
          state_d = ABORT;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      consec_q <= {CONSEC_W{1'b0}};
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      consec_q <= consec_d;
      err_q    <= err_d;
    end
  end

  // RAM-side mux, silent outside an active ownership
  always_comb begin
    p_wb_CYC_O  = 1'b0;
    p_wb_STB_O  = 1'b0;
    p_wb_LOCK_O = 1'b0;
    p_wb_WE_O   = 1'b0;
    p_wb_SEL_O  = {WB_SEL_W{1'b0}};
    p_wb_ADR_O  = {ADR_W{1'b0}};
    if (owning_s) begin
      p_wb_CYC_O  = owner_cyc_s;
      p_wb_STB_O  = owner_stb_s;
      p_wb_LOCK_O = owner_lock_s;
      p_wb_WE_O   = owner_we_s;
      p_wb_SEL_O  = owner_sel_s;
      p_wb_ADR_O  = owner_adr_s;
    end else begin
      p_wb_CYC_O  = 1'b0;
    end
  end

  assign m0_wb_ACK_O = p_wb_ACK_I & grant_q[0] & (state_q != ABORT);
  assign m1_wb_ACK_O = p_wb_ACK_I & grant_q[1] & (state_q != ABORT);
  assign m0_wb_DAT_O = p_wb_DAT_I;
  assign m1_wb_DAT_O = p_wb_DAT_I;
  assign m0_err      = err_q[0];
  assign m1_err      = err_q[1];
  assign grant       = grant_q;

endmodule

// File: tb/tb_wb_fill_arbiter.sv
// Randomized bench for wb_fill_arbiter against an ownership-level reference
// model, plus directed scenarios with hand-computed expectations.
module tb_wb_fill_arbiter;

  localparam int MAXC = 2;
  localparam int TO   = 255;

  logic        clk = 1'b0;
  logic        nRST;
  logic [1:0]  cyc, stb, lock, we;
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] p_dat;
  logic        p_ack;

  logic        m0_ack, m1_ack, m0_err_o, m1_err_o;
  logic [31:0] m0_dat, m1_dat;
  logic        p_cyc_o, p_stb_o, p_lock_o, p_we_o;
  logic [3:0]  p_sel_o;
  logic [31:0] p_adr_o;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  wb_fill_arbiter #(.ADR_W(32), .MAX_CONSEC(MAXC), .TIMEOUT(TO)) dut (
    .clk(clk), .nRST(nRST),
    .m0_wb_CYC_I(cyc[0]), .m0_wb_STB_I(stb[0]), .m0_wb_LOCK_I(lock[0]),
    .m0_wb_SEL_I(sel[0]), .m0_wb_WE_I(we[0]), .m0_wb_ADR_I(adr[0]),
    .m0_wb_ACK_O(m0_ack), .m0_wb_DAT_O(m0_dat), .m0_err(m0_err_o),
    .m1_wb_CYC_I(cyc[1]), .m1_wb_STB_I(stb[1]), .m1_wb_LOCK_I(lock[1]),
    .m1_wb_SEL_I(sel[1]), .m1_wb_WE_I(we[1]), .m1_wb_ADR_I(adr[1]),
    .m1_wb_ACK_O(m1_ack), .m1_wb_DAT_O(m1_dat), .m1_err(m1_err_o),
    .p_wb_DAT_I(p_dat), .p_wb_ACK_I(p_ack),
    .p_wb_CYC_O(p_cyc_o), .p_wb_STB_O(p_stb_o), .p_wb_LOCK_O(p_lock_o),
    .p_wb_WE_O(p_we_o), .p_wb_SEL_O(p_sel_o), .p_wb_ADR_O(p_adr_o),
    .grant(grant)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: who owns the port, and why ----------
  int       own    = 0;   // 0 nobody, 1 m0, 2 m1
  bit       ab     = 0;   // owner was aborted by the watchdog
  int       stall  = 0;   // consecutive strobe cycles without ACK
  int       consec = 0;   // m0 wins in a row while m1 was asking
  bit [1:0] err_e  = 2'b00;

  task automatic enter(input int w);
    own   = w + 1;
    stall = 0;
    if (w == 0 && cyc[1]) consec = (consec < MAXC) ? consec + 1 : consec;
    else                  consec = 0;
  endtask

  task automatic model_step();
    int o;
    if (!nRST) begin
      own = 0; ab = 0; stall = 0; consec = 0; err_e = 2'b00;
      return;
    end
    err_e = 2'b00;
    if (own == 0) begin
      if (cyc == 2'b11)      enter((consec == MAXC) ? 1 : 0);
      else if (cyc[0])       enter(0);
      else if (cyc[1])       enter(1);
    end else if (ab) begin
      if (!cyc[own-1]) begin own = 0; ab = 0; end
    end else begin
      o = own - 1;
      if (!cyc[o] && !lock[o]) begin
        stall = 0;
        if (cyc[1-o]) enter(1 - o);
        else          own = 0;
      end else if (stb[o] && !p_ack) begin
        stall++;
        if (stall == TO) begin ab = 1; err_e[o] = 1'b1; stall = 0; end
      end else begin
        stall = 0;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Every cycle: DUT outputs against what the model says they must be
  always @(negedge clk) begin
    int o;
    bit bus;
    logic [1:0] g;
    o   = (own == 2) ? 1 : 0;
    bus = (own != 0) && !ab;
    g   = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
    chk("grant",  64'(grant),    64'(g));
    chk("p_cyc",  64'(p_cyc_o),  64'(bus ? cyc[o]  : 1'b0));
    chk("p_stb",  64'(p_stb_o),  64'(bus ? stb[o]  : 1'b0));
    chk("p_lock", 64'(p_lock_o), 64'(bus ? lock[o] : 1'b0));
    chk("p_we",   64'(p_we_o),   64'(bus ? we[o]   : 1'b0));
    chk("p_sel",  64'(p_sel_o),  64'(bus ? sel[o]  : 4'h0));
    chk("p_adr",  64'(p_adr_o),  64'(bus ? adr[o]  : 32'h0));
    chk("m0_ack", 64'(m0_ack),   64'(p_ack && own == 1 && !ab));
    chk("m1_ack", 64'(m1_ack),   64'(p_ack && own == 2 && !ab));
    chk("m0_err", 64'(m0_err_o), 64'(err_e[0]));
    chk("m1_err", 64'(m1_err_o), 64'(err_e[1]));
    chk("m0_dat", 64'(m0_dat),   64'(p_dat));
    chk("m1_dat", 64'(m1_dat),   64'(p_dat));
  end

  // ---------------- stimulus ---------------------------------------------
  int       ack_mode = 0;  // 0 never, 1 random 60%, 2 every strobe
  bit [1:0] a_seen   = 2'b00;

  // Close the current cycle: drive the RAM ACK, note master ACKs, move on
  task automatic next_cycle();
    #1;
    case (ack_mode)
      0:       p_ack = 1'b0;
      1:       p_ack = p_stb_o && ($urandom_range(0, 99) < 60);
      default: p_ack = p_stb_o;
    endcase
    p_dat = $urandom();
    #1;
    a_seen = {m1_ack, m0_ack};
    @(negedge clk);
    #1;
  endtask

  int beats [2];
  int gap   [2];
  int lhold [2];
  bit act   [2];

  initial begin
    int n, cnt, hits, errs;
    nRST = 1'b0; cyc = 2'b00; stb = 2'b00; lock = 2'b00; we = 2'b00;
    p_ack = 1'b0; p_dat = 32'h0;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 4'hF; adr[i] = 32'h1000 * (i + 1);
      beats[i] = 0; gap[i] = 0; lhold[i] = 0; act[i] = 1'b0;
    end

    // Reset held with both masters requesting
    cyc = 2'b11; stb = 2'b11;
    repeat (3) next_cycle();
    chk("rst_grant", 64'(grant), 64'(2'b00));
    chk("rst_cyc",   64'(p_cyc_o), 64'(1'b0));
    nRST = 1'b1; ack_mode = 2;
    next_cycle();
    chk("post_rst_grant", 64'(grant), 64'(2'b01));

    // m0 26-beat burst with m1 waiting, then direct handoff
    cnt = 0; hits = 0;
    for (int i = 0; i < 100 && cnt < 26; i++) begin
      next_cycle();
      cnt  += int'(a_seen[0]);
      hits += int'(a_seen[1]);
      adr[0] = adr[0] + 32'd4;
    end
    chk("m0_beats", 64'(cnt), 64'(26));
    chk("m1_ack_during_m0", 64'(hits), 64'(0));
    cyc[0] = 1'b0; stb[0] = 1'b0;
    next_cycle();
    chk("handoff_grant", 64'(grant), 64'(2'b10));
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 3; i++) begin next_cycle(); cnt += int'(a_seen[1]); end
    chk("m1_beats", 64'(cnt), 64'(3));
    cyc[1] = 1'b0; stb[1] = 1'b0;
    next_cycle();
    chk("idle_grant", 64'(grant), 64'(2'b00));

    // LOCK keeps m1's grant across a CYC gap
    cyc[1] = 1'b1; stb[1] = 1'b1; lock[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin next_cycle(); cnt += int'(a_seen[1]); end
    cyc[1] = 1'b0; stb[1] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      chk("lock_grant", 64'(grant), 64'(2'b10));
      chk("lock_cyc",   64'(p_cyc_o), 64'(1'b0));
    end
    lock[1] = 1'b0;
    next_cycle();
    chk("unlock_grant", 64'(grant), 64'(2'b01));
    cyc[0] = 1'b0; stb[0] = 1'b0;
    next_cycle();

    // Anti-starvation: m1 withdraws twice, third contested arbitration is m1's
    for (int r = 0; r < 4; r++) begin
      logic [1:0] eg;
      eg = (r == 2) ? 2'b10 : 2'b01;
      cyc = 2'b11; stb = 2'b11;
      next_cycle();
      chk("starve_grant", 64'(grant), 64'(eg));
      cyc = 2'b00; stb = 2'b00;
      next_cycle();
      chk("starve_idle", 64'(grant), 64'(2'b00));
    end

    // Watchdog: RAM never answers m0
    ack_mode = 0; cyc[0] = 1'b1; stb[0] = 1'b1;
    n = 0;
    while (n < 400 && !m0_err_o) begin next_cycle(); n++; end
    chk("wd_latency", 64'(n), 64'(256));
    chk("wd_cyc",     64'(p_cyc_o), 64'(1'b0));
    chk("wd_grant",   64'(grant), 64'(2'b01));
    next_cycle();
    chk("wd_pulse_once", 64'(m0_err_o), 64'(1'b0));
    cyc[0] = 1'b0; stb[0] = 1'b0;
    next_cycle();
    chk("wd_to_idle", 64'(grant), 64'(2'b00));

    // ACK on the very cycle the timeout would hit: delivered, no abort
    cyc[0] = 1'b1; stb[0] = 1'b1;
    errs = 0; cnt = 0;
    for (int k = 0; k < 262; k++) begin
      ack_mode = (k == 255) ? 2 : 0;
      next_cycle();
      errs += int'(m0_err_o);
      cnt  += int'(a_seen[0]);
    end
    chk("race_err",   64'(errs), 64'(0));
    chk("race_acks",  64'(cnt),  64'(1));
    chk("race_grant", 64'(grant), 64'(2'b01));
    cyc[0] = 1'b0; stb[0] = 1'b0;
    next_cycle();

    // Random traffic from both masters, with a reset dropped mid-stream
    ack_mode = 1; a_seen = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      bit [1:0] errv;
      if (c == 1500) nRST = 1'b0;
      if (c == 1502) nRST = 1'b1;
      errv = {m1_err_o, m0_err_o};
      for (int m = 0; m < 2; m++) begin
        if (act[m]) begin
          if (errv[m]) begin
            cyc[m] = 1'b0; stb[m] = 1'b0; lock[m] = 1'b0; act[m] = 1'b0;
            gap[m] = $urandom_range(0, 3);
          end else begin
            if (a_seen[m]) begin
              beats[m]--;
              adr[m] = $urandom(); we[m] = 1'($urandom_range(0, 1)); sel[m] = 4'($urandom());
            end
            if (beats[m] == 0) begin
              cyc[m] = 1'b0; stb[m] = 1'b0; act[m] = 1'b0;
              gap[m] = $urandom_range(0, 3);
              lhold[m] = lock[m] ? $urandom_range(1, 4) : 0;
            end else begin
              stb[m] = ($urandom_range(0, 4) != 0);
            end
          end
        end else if (lhold[m] > 0) begin
          lhold[m]--;
          if (lhold[m] == 0) lock[m] = 1'b0;
        end else if (gap[m] > 0) begin
          gap[m]--;
        end else if ($urandom_range(0, 3) == 0) begin
          act[m] = 1'b1; cyc[m] = 1'b1; stb[m] = 1'b1;
          lock[m] = ($urandom_range(0, 4) == 0);
          beats[m] = (m == 0 && $urandom_range(0, 2) == 0) ? 26 : $urandom_range(1, 5);
          adr[m] = $urandom(); we[m] = 1'($urandom_range(0, 1)); sel[m] = 4'($urandom());
        end
      end
      next_cycle();
      if (c == 1500) chk("midburst_rst_cyc", 64'(p_cyc_o), 64'(1'b0));
    end

    cyc = 2'b00; stb = 2'b00; lock = 2'b00;
    repeat (3) next_cycle();
    chk("final_idle", 64'(grant), 64'(2'b00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
